alu_cmd_issue: RTL and testbench
================================

Name: alu_cmd_issue

Overview:
Registered command-issue stage that sits directly upstream of the combinational 8-bit ALU.
- Accepts operand/opcode commands over a valid/ready handshake and buffers them in a small FIFO.
- Drives the FIFO head onto the ALU's a/b/op inputs.
- Captures the ALU result into a valid/ready output register, so the combinational ALU gains flow control and a registered result.

Parameters:
DATA_W, 8, operand and result width (matches ALU).
OP_W, 3, opcode width (matches ALU).
DEPTH, 4, command FIFO entries; power of 2, minimum 2.

Ports:
clk  input  1  clock, rising edge.
reset  input  1  asynchronous, active-low reset.
cmd_valid_i  input  1  command present.
cmd_ready_o  output  1  FIFO can accept a command.
cmd_a_i  input  DATA_W  operand A.
cmd_b_i  input  DATA_W  operand B.
cmd_op_i  input  OP_W  opcode.
alu_a_o  output  DATA_W  to ALU a input.
alu_b_o  output  DATA_W  to ALU b input.
alu_op_o  output  OP_W  to ALU op input.
alu_res_i  input  DATA_W  from ALU output (combinational).
res_valid_o  output  1  result register holds a result.
res_ready_i  input  1  consumer accepts result.
res_data_o  output  DATA_W  registered ALU result.
res_op_o  output  OP_W  opcode that produced res_data_o.
count_o  output  $clog2(DEPTH)+1  FIFO occupancy.

Behaviour:
Reset (reset low, asynchronous):
- FIFO pointers and count clear to 0.
- res_valid_o=0, res_data_o=0, res_op_o=0.
- Pending commands and an unconsumed result are discarded, including when reset is asserted mid-operation.

Push:
- cmd_ready_o = (count_o < DEPTH), combinational from count only.
- Push occurs on an edge where cmd_valid_i && cmd_ready_o; the entry is written at the tail.

ALU drive:
- FIFO non-empty: alu_a_o/alu_b_o/alu_op_o = head entry, taken straight from storage, no combinational path from cmd_* inputs.
- FIFO empty: all three are driven to 0.

Output register (2 states):
- EMPTY (res_valid_o=0) or FULL (res_valid_o=1).
- Issue condition: FIFO non-empty && (res_valid_o==0 || res_ready_i).
- On issue: pop head; res_data_o<=alu_res_i; res_op_o<=alu_op_o; res_valid_o<=1.
- FULL && res_ready_i && no issue: res_valid_o<=0. res_data_o/res_op_o hold their last value.
- FULL && !res_ready_i: hold everything; no pop (backpressure fills the FIFO).

Latency and throughput:
- Command accepted at edge N reaches the ALU inputs after edge N.
- Its result is valid after edge N+1, assuming an empty FIFO and empty or draining output.
- Throughput is 1 result per cycle with res_ready_i held high.

Simultaneous events and boundaries:
- Push and pop on the same edge: count unchanged; both pointers advance.
- Full: cmd_ready_o=0; push ignored even if a pop happens the same edge (no pass-through).
- Empty: no issue; alu_* driven to 0.
- Pointers wrap modulo DEPTH; count distinguishes full from empty.
- Results are produced in strict FIFO order.

Optional Feature:
Macro ALU_ISSUE_STATS_EN.
- Defined: adds output retired_cnt_o [15:0]. Increments on each edge where res_valid_o && res_ready_i. Wraps 0xFFFF->0x0000. Reset to 0.
- Undefined: port and counter are absent; all other behaviour is identical.

Test Plan:
The bench ALU model is alu_res_i = alu_a_o ^ alu_b_o.
1. Reset low mid-stream with 3 entries queued and res_valid_o=1 -> immediately count_o=0, res_valid_o=0, alu_a_o=0, cmd_ready_o=1 after release.
2. Single command a=0x5A, b=0x0F, op=3 at edge N, res_ready_i=1 -> after edge N+1: res_valid_o=1, res_data_o=0x55, res_op_o=3; after edge N+2: res_valid_o=0.
3. res_ready_i=0, push 5 commands -> one issues to the output register, 4 fill the FIFO; count_o=4, cmd_ready_o=0; 6th cmd_valid_i not accepted. Then res_ready_i=1 -> 5 results drain in push order, one per cycle.
4. Streaming: cmd_valid_i=1 and res_ready_i=1 for 20 cycles with random operands -> count_o never exceeds 1, 20 results in order, no bubbles after the first.
5. Push and pop on the same edge at count_o=2 -> count_o stays 2; head advances; wrap-around past entry DEPTH-1 is correct over 10 cycles.
6. ALU_ISSUE_STATS_EN defined, retire 3 results with res_ready_i toggling -> retired_cnt_o=3; with counter preloaded via 65536 retires, it wraps to 0.

Source files
------------

// File: rtl/alu_cmd_issue.sv
// Command-issue stage for the combinational 8-bit ALU. It buffers commands in a FIFO, drives the ALU from the FIFO head and registers the result.
// Optional build macro: ALU_ISSUE_STATS_EN adds retired_cnt_o, a 16-bit count of results accepted by the consumer.
module alu_cmd_issue #(
  parameter int DATA_W = 8,
  parameter int OP_W   = 3,
  parameter int DEPTH  = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     cmd_valid_i,
  output logic                     cmd_ready_o,
  input  logic [DATA_W-1:0]        cmd_a_i,
  input  logic [DATA_W-1:0]        cmd_b_i,
  input  logic [OP_W-1:0]          cmd_op_i,
  output logic [DATA_W-1:0]        alu_a_o,
  output logic [DATA_W-1:0]        alu_b_o,
  output logic [OP_W-1:0]          alu_op_o,
  input  logic [DATA_W-1:0]        alu_res_i,
  output logic                     res_valid_o,
  input  logic                     res_ready_i,
  output logic [DATA_W-1:0]        res_data_o,
  output logic [OP_W-1:0]          res_op_o,
  output logic [$clog2(DEPTH):0]   count_o
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [15:0]              retired_cnt_o
`endif
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {
    S_EMPTY = 1'b0,
    S_FULL  = 1'b1
  } state_t;

  // Both interfaces use valid/ready: a transfer happens on a rising edge where
  // valid and ready are both high; valid never waits on ready, and ready is
  // derived from registered state only.

  logic [DATA_W-1:0] r_mem_a  [DEPTH];
  logic [DATA_W-1:0] r_mem_b  [DEPTH];
  logic [OP_W-1:0]   r_mem_op [DEPTH];

  logic [PTR_W-1:0]  r_wr_ptr;
  logic [PTR_W-1:0]  r_rd_ptr;
  logic [CNT_W-1:0]  r_count;
  state_t            r_state;
  state_t            w_state_nxt;
  logic [DATA_W-1:0] r_res_data;
  logic [OP_W-1:0]   r_res_op;

  logic w_empty;
  logic w_push;
  logic w_issue;

  assign w_empty     = (r_count == '0);
  assign cmd_ready_o = (r_count < CNT_W'(DEPTH));
  assign w_push      = cmd_valid_i && cmd_ready_o;
  assign w_issue     = !w_empty && ((r_state == S_EMPTY) || res_ready_i);

  // Head is read straight from storage so no cmd_* input reaches the ALU combinationally.
  assign alu_a_o  = w_empty ? '0 : r_mem_a[r_rd_ptr];
  assign alu_b_o  = w_empty ? '0 : r_mem_b[r_rd_ptr];
  assign alu_op_o = w_empty ? '0 : r_mem_op[r_rd_ptr];

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_a[r_wr_ptr]  <= cmd_a_i;
      r_mem_b[r_wr_ptr]  <= cmd_b_i;
      r_mem_op[r_wr_ptr] <= cmd_op_i;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_issue) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      if (w_push && !w_issue) begin
        r_count <= r_count + CNT_W'(1);
      end else if (!w_push && w_issue) begin
        r_count <= r_count - CNT_W'(1);
      end
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_EMPTY: begin
        if (w_issue) begin
          w_state_nxt = S_FULL;
        end
      end
      S_FULL: begin
        if (w_issue) begin
          w_state_nxt = S_FULL;
        end else if (res_ready_i) begin
          w_state_nxt = S_EMPTY;
        end
      end
      default: w_state_nxt = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state    <= S_EMPTY;
      r_res_data <= '0;
      r_res_op   <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_issue) begin
        r_res_data <= alu_res_i;
        r_res_op   <= alu_op_o;
      end
    end
  end

  assign res_valid_o = (r_state == S_FULL);
  assign res_data_o  = r_res_data;
  assign res_op_o    = r_res_op;
  assign count_o     = r_count;

`ifdef ALU_ISSUE_STATS_EN
  logic [15:0] r_retired;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_retired <= '0;
    end else if (res_valid_o && res_ready_i) begin
      r_retired <= r_retired + 16'd1;
    end
  end

  assign retired_cnt_o = r_retired;
`endif

endmodule

// File: tb/tb_alu_cmd_issue.sv
// Bench for alu_cmd_issue: directed vector table plus multi-cycle sequences, with an XOR ALU model.
// Build with ALU_ISSUE_STATS_EN defined to also exercise retired_cnt_o.
module tb_alu_cmd_issue;

  localparam int DATA_W = 8;
  localparam int OP_W   = 3;
  localparam int DEPTH  = 4;

  logic              clk;
  logic              reset;
  logic              cmd_valid_i;
  logic              cmd_ready_o;
  logic [DATA_W-1:0] cmd_a_i;
  logic [DATA_W-1:0] cmd_b_i;
  logic [OP_W-1:0]   cmd_op_i;
  logic [DATA_W-1:0] alu_a_o;
  logic [DATA_W-1:0] alu_b_o;
  logic [OP_W-1:0]   alu_op_o;
  logic [DATA_W-1:0] alu_res_i;
  logic              res_valid_o;
  logic              res_ready_i;
  logic [DATA_W-1:0] res_data_o;
  logic [OP_W-1:0]   res_op_o;
  logic [2:0]        count_o;
`ifdef ALU_ISSUE_STATS_EN
  logic [15:0]       retired_cnt_o;
`endif

  alu_cmd_issue #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W),
    .DEPTH  (DEPTH)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid_i (cmd_valid_i),
    .cmd_ready_o (cmd_ready_o),
    .cmd_a_i     (cmd_a_i),
    .cmd_b_i     (cmd_b_i),
    .cmd_op_i    (cmd_op_i),
    .alu_a_o     (alu_a_o),
    .alu_b_o     (alu_b_o),
    .alu_op_o    (alu_op_o),
    .alu_res_i   (alu_res_i),
    .res_valid_o (res_valid_o),
    .res_ready_i (res_ready_i),
    .res_data_o  (res_data_o),
    .res_op_o    (res_op_o),
    .count_o     (count_o)
`ifdef ALU_ISSUE_STATS_EN
    ,
    .retired_cnt_o (retired_cnt_o)
`endif
  );

  assign alu_res_i = alu_a_o ^ alu_b_o;

  // ---------------- clock ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- scoreboard ----------------
  logic [OP_W+DATA_W-1:0] exp_q[$];
  int n_pass;
  int n_total;
  int n_retired;

  typedef struct {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
    logic [OP_W-1:0]   op;
    logic [DATA_W-1:0] exp_res;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Observe handshakes for the coming edge, then advance to just after it.
  task automatic tick();
    logic [OP_W+DATA_W-1:0] e;
    if (cmd_valid_i && cmd_ready_o) begin
      exp_q.push_back({cmd_op_i, cmd_a_i ^ cmd_b_i});
    end
    if (res_valid_o && res_ready_i) begin
      n_retired++;
      if (exp_q.size() == 0) begin
        check("unexpected_result", 32'd1, 32'd0);
      end else begin
        e = exp_q.pop_front();
        check("sb_res_data", 32'(res_data_o), 32'(e[DATA_W-1:0]));
        check("sb_res_op", 32'(res_op_o), 32'(e[OP_W+DATA_W-1:DATA_W]));
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic set_cmd(input logic v, input logic [7:0] a, input logic [7:0] b, input logic [2:0] op);
    cmd_valid_i = v;
    cmd_a_i     = a;
    cmd_b_i     = b;
    cmd_op_i    = op;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    #3;
    exp_q.delete();
    n_retired = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    vecs[0] = '{8'h5A, 8'h0F, 3'd3, 8'h55};
    vecs[1] = '{8'hFF, 8'h0F, 3'd1, 8'hF0};
    vecs[2] = '{8'h00, 8'h00, 3'd0, 8'h00};
    vecs[3] = '{8'hA5, 8'h5A, 3'd7, 8'hFF};
    vecs[4] = '{8'h81, 8'h18, 3'd5, 8'h99};

    n_pass = 0;
    n_total = 0;
    n_retired = 0;
    set_cmd(1'b0, 8'h00, 8'h00, 3'd0);
    res_ready_i = 1'b0;
    reset = 1'b1;
    #2;
    do_reset();

    check("rst_count", 32'(count_o), 32'd0);
    check("rst_res_valid", 32'(res_valid_o), 32'd0);
    check("rst_res_data", 32'(res_data_o), 32'd0);
    check("rst_cmd_ready", 32'(cmd_ready_o), 32'd1);
    check("rst_alu_a_empty", 32'(alu_a_o), 32'd0);

    // Test 1: reset mid-stream with 3 queued and a held result.
    res_ready_i = 1'b0;
    for (int i = 0; i < 4; i++) begin
      set_cmd(1'b1, 8'(8'h10 + i), 8'h01, 3'(i));
      tick();
    end
    set_cmd(1'b0, 8'h00, 8'h00, 3'd0);
    check("t1_pre_count", 32'(count_o), 32'd3);
    check("t1_pre_valid", 32'(res_valid_o), 32'd1);
    #2;
    reset = 1'b0;
    #1;
    check("t1_async_count", 32'(count_o), 32'd0);
    check("t1_async_valid", 32'(res_valid_o), 32'd0);
    check("t1_async_alu_a", 32'(alu_a_o), 32'd0);
    check("t1_async_data", 32'(res_data_o), 32'd0);
    exp_q.delete();
    n_retired = 0;
    @(posedge clk);
    #1;
    reset = 1'b1;
    tick();
    check("t1_post_ready", 32'(cmd_ready_o), 32'd1);
    check("t1_post_count", 32'(count_o), 32'd0);

    // Test 2: table of single commands, hand-computed XOR results.
    res_ready_i = 1'b1;
    for (int v = 0; v < 5; v++) begin
      set_cmd(1'b1, vecs[v].a, vecs[v].b, vecs[v].op);
      tick();
      set_cmd(1'b0, 8'h00, 8'h00, 3'd0);
      check("t2_alu_a", 32'(alu_a_o), 32'(vecs[v].a));
      check("t2_alu_op", 32'(alu_op_o), 32'(vecs[v].op));
      check("t2_n1_valid", 32'(res_valid_o), 32'd0);
      tick();
      check("t2_n2_valid", 32'(res_valid_o), 32'd1);
      check("t2_res_data", 32'(res_data_o), 32'(vecs[v].exp_res));
      check("t2_res_op", 32'(res_op_o), 32'(vecs[v].op));
      check("t2_alu_a_empty", 32'(alu_a_o), 32'd0);
      tick();
      check("t2_n3_valid", 32'(res_valid_o), 32'd0);
      check("t2_hold_data", 32'(res_data_o), 32'(vecs[v].exp_res));
    end

    // Test 3: backpressure fills the FIFO, then drains in order.
    res_ready_i = 1'b0;
    for (int i = 0; i < 5; i++) begin
      set_cmd(1'b1, 8'(8'h30 + 8'(i * 7)), 8'(8'hC0 + i), 3'(i + 2));
      tick();
    end
    check("t3_full_count", 32'(count_o), 32'd4);
    check("t3_full_ready", 32'(cmd_ready_o), 32'd0);
    set_cmd(1'b1, 8'hEE, 8'h11, 3'd6);
    tick();
    set_cmd(1'b0, 8'h00, 8'h00, 3'd0);
    check("t3_no_accept", 32'(count_o), 32'd4);
    check("t3_sb_depth", 32'(exp_q.size()), 32'd5);
    res_ready_i = 1'b1;
    for (int i = 0; i < 5; i++) begin
      check("t3_drain_valid", 32'(res_valid_o), 32'd1);
      tick();
    end
    check("t3_drained_valid", 32'(res_valid_o), 32'd0);
    check("t3_drained_count", 32'(count_o), 32'd0);

    // Test 4: streaming at full rate.
    n_retired = 0;
    for (int i = 0; i < 20; i++) begin
      set_cmd(1'b1, 8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 3'($urandom_range(0, 7)));
      if (count_o > 3'd1) check("t4_count_le1", 32'(count_o), 32'd1);
      if (i >= 2) check("t4_no_bubble", 32'(res_valid_o), 32'd1);
      tick();
    end
    set_cmd(1'b0, 8'h00, 8'h00, 3'd0);
    tick();
    tick();
    check("t4_retired", 32'(n_retired), 32'd20);
    check("t4_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t4_idle_valid", 32'(res_valid_o), 32'd0);

    // Test 5: push and pop on the same edge at count 2, across pointer wrap.
    res_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b1, 8'(8'h50 + i), 8'h0A, 3'(i));
      tick();
    end
    check("t5_pre_count", 32'(count_o), 32'd2);
    res_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      set_cmd(1'b1, 8'(8'h60 + 8'(i * 3)), 8'(8'h0F - i), 3'(i));
      check("t5_head", 32'({alu_op_o, alu_a_o ^ alu_b_o}), 32'(exp_q[1]));
      tick();
      check("t5_count_steady", 32'(count_o), 32'd2);
    end
    set_cmd(1'b0, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 4; i++) tick();
    check("t5_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t5_final_count", 32'(count_o), 32'd0);

`ifdef ALU_ISSUE_STATS_EN
    // Test 6: retire counter with toggling ready, then wrap.
    do_reset();
    check("t6_rst_cnt", 32'(retired_cnt_o), 32'd0);
    res_ready_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      set_cmd(1'b1, 8'(8'h70 + i), 8'h33, 3'(i));
      tick();
    end
    set_cmd(1'b0, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 8; i++) begin
      res_ready_i = ~res_ready_i;
      tick();
    end
    check("t6_cnt3", 32'(retired_cnt_o), 32'd3);
    res_ready_i = 1'b1;
    for (int i = 0; i < 65533; i++) begin
      set_cmd(1'b1, 8'(i), 8'(i >> 8), 3'(i));
      tick();
    end
    set_cmd(1'b0, 8'h00, 8'h00, 3'd0);
    for (int i = 0; i < 3; i++) tick();
    check("t6_sb_empty", 32'(exp_q.size()), 32'd0);
    check("t6_wrap", 32'(retired_cnt_o), 32'd0);
`endif

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
